// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the single-issue MIPS datapath.
// Build option: define MC_ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky TRAP state.
module multicycle_ctrl_fsm #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_J     = 6'b000010,
  parameter logic [5:0]  OP_ADDI  = 6'b001000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             ir_load,
  output logic             reg_dst,
  output logic             jump,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             pc_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
`ifdef MC_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP   = 3'd5;
`endif

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  logic [2:0]       state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

  // Next state and Moore-style control decode from state_q and latched op_q.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ir_load    = 1'b0;
    reg_dst    = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    pc_en      = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        // Keep ir_load quiet while reset is still held.
        ir_load = imem_ready & ~reset;
        if (imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = opcode;
        if (is_supported(opcode)) begin
          state_d = S_EXEC;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          pc_en   = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_RTYPE: begin
            alu_op  = ALU_FUNCT;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            alu_op  = ALU_SUB;
            branch  = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
          OP_J: begin
            jump    = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        alu_src = 1'b1;
        if (op_q == OP_LW) begin
          mem_read = 1'b1;
          if (dmem_ready) state_d = S_WB;
        end else begin
          mem_write = 1'b1;
          if (dmem_ready) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_en      = 1'b1;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LW);
        alu_src    = (op_q != OP_RTYPE);
        alu_op     = (op_q == OP_RTYPE) ? ALU_FUNCT : ALU_ADD;
        state_d    = S_FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    count_d = count_q + CNT_W'(pc_en);
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: random instruction streams checked against a
// cycle-position model derived from per-opcode latencies; honours MC_ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl_fsm;

  localparam int unsigned CNT_W = 4;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             imem_ready, dmem_ready;
  logic             ir_load, reg_dst, jump, branch, mem_read, mem_write, mem_to_reg, alu_src;
  logic [1:0]       alu_op;
  logic             reg_write, pc_en;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;
`ifdef MC_ILLEGAL_TRAP_EN
  logic             illegal;
`endif

  logic [14:0]      got_ctl;
  logic [CNT_W-1:0] exp_cnt;
  int               n_checks = 0;
  int               n_pass   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .ir_load     (ir_load),
    .reg_dst     (reg_dst),
    .jump        (jump),
    .branch      (branch),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .pc_en       (pc_en),
    .state       (state),
    .instr_count (instr_count)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .illegal     (illegal)
`endif
  );

  assign got_ctl = {ir_load, reg_dst, jump, branch, mem_read, mem_write, mem_to_reg,
                    alu_src, alu_op, reg_write, pc_en, state};

  function automatic bit is_sup(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  // Cycles from the imem_ready cycle onward; unsupported opcodes retire in DECODE.
  function automatic int lat(input logic [5:0] op, input int mw);
    if (op == OP_R || op == OP_ADDI) return 4;
    if (op == OP_LW) return 5 + mw;
    if (op == OP_SW) return 4 + mw;
    if (op == OP_BEQ || op == OP_J) return 3;
    return 2;
  endfunction

  // Expected control vector at cycle k of an instruction, from its position in the timeline.
  function automatic logic [14:0] exp_ctl(input logic [5:0] op, input int fw, input int mw,
                                          input int k, input int last);
    logic [2:0] st;
    logic [1:0] aop;
    logic       asrc, fin, memop, wbop;
    memop = (op == OP_LW) || (op == OP_SW);
    wbop  = (op == OP_R) || (op == OP_ADDI) || (op == OP_LW);
    fin   = (k == last);
    if (k <= fw)                         st = 3'd0;
    else if (k == fw + 1)                st = 3'd1;
    else if (k == fw + 2)                st = 3'd2;
    else if (memop && k <= fw + 3 + mw)  st = 3'd3;
    else                                 st = 3'd4;
    aop = 2'b00;
    if (op == OP_R && (st == 3'd2 || st == 3'd4)) aop = 2'b10;
    else if (op == OP_BEQ && st == 3'd2)          aop = 2'b01;
    asrc = (st >= 3'd2) && (op == OP_LW || op == OP_SW || op == OP_ADDI);
    return {(k == fw), (op == OP_R) && fin, (op == OP_J) && fin, (op == OP_BEQ) && fin,
            (op == OP_LW) && (st == 3'd3), (op == OP_SW) && (st == 3'd3),
            (op == OP_LW) && fin, asrc, aop, wbop && fin, fin, st};
  endfunction

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int abort_k);
    int          last;
    int          mem_hi;
    logic [14:0] e;
    last   = fw + lat(op, mw) - 1;
    mem_hi = fw + 3 + mw;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == abort_k) break;
      imem_ready = (k < fw) ? 1'b0 : (k == fw) ? 1'b1 : 1'($urandom_range(0, 1));
      opcode     = (k == fw + 1) ? op : 6'($urandom);
      if ((op == OP_LW || op == OP_SW) && k >= fw + 3 && k <= mem_hi)
        dmem_ready = (k == mem_hi);
      else
        dmem_ready = 1'($urandom_range(0, 1));
      #1;
      e = exp_ctl(op, fw, mw, k, last);
      n_checks++;
      if (got_ctl !== e)
        $display("FAIL ctl op=%b fw=%0d mw=%0d k=%0d got=%b exp=%b", op, fw, mw, k, got_ctl, e);
      else n_pass++;
      n_checks++;
      if (instr_count !== exp_cnt)
        $display("FAIL instr_count op=%b k=%0d got=%0d exp=%0d", op, k, instr_count, exp_cnt);
      else n_pass++;
    end
    if (abort_k < 0) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if (got_ctl !== 15'd0 || instr_count !== '0)
      $display("FAIL %s got_ctl=%b cnt=%0d exp_ctl=0 cnt=0", tag, got_ctl, instr_count);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 6'd0;
    #1;
    check_idle("reset_initial");
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset_held");
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_rtype();
    run_instr(OP_R, 0, 0, -1);
    run_instr(OP_ADDI, 0, 0, -1);
  endtask

  task automatic test_lw_wait();
    run_instr(OP_LW, 0, 3, -1);
  endtask

  task automatic test_back_to_back();
    run_instr(OP_SW, 0, 0, -1);
    run_instr(OP_BEQ, 0, 0, -1);
    run_instr(OP_J, 0, 0, -1);
  endtask

  task automatic test_fetch_wait();
    run_instr(OP_R, 5, 0, -1);
    run_instr(OP_SW, 2, 2, -1);
  endtask

  task automatic test_reset_mid_mem();
    logic [14:0] e;
    run_instr(OP_LW, 1, 10, 6);
    imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 6'($urandom);
    #1;
    e = exp_ctl(OP_LW, 1, 10, 6, 16);
    n_checks++;
    if (got_ctl !== e) $display("FAIL pre_reset_mem got=%b exp=%b", got_ctl, e);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    check_idle("reset_mid_mem");
    @(negedge clk);
    #1;
    check_idle("reset_mid_mem_held");
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_illegal();
`ifdef MC_ILLEGAL_TRAP_EN
    @(negedge clk);
    imem_ready = 1'b1; opcode = 6'($urandom); dmem_ready = 1'($urandom_range(0, 1));
    #1;
    n_checks++;
    if (got_ctl !== 15'h4000) $display("FAIL trap_fetch got=%b exp=%b", got_ctl, 15'h4000);
    else n_pass++;
    @(negedge clk);
    imem_ready = 1'($urandom_range(0, 1)); opcode = 6'b111111;
    #1;
    n_checks++;
    if (got_ctl !== 15'd1) $display("FAIL trap_decode got=%b exp=%b", got_ctl, 15'd1);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_ready = 1'($urandom_range(0, 1)); dmem_ready = 1'($urandom_range(0, 1));
      opcode = 6'($urandom);
      #1;
      n_checks++;
      if (got_ctl !== 15'd5 || illegal !== 1'b1 || instr_count !== exp_cnt)
        $display("FAIL trap_hold i=%0d got=%b ill=%b cnt=%0d exp=%b ill=1 cnt=%0d",
                 i, got_ctl, illegal, instr_count, 15'd5, exp_cnt);
      else n_pass++;
    end
    imem_ready = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (got_ctl !== 15'd0 || illegal !== 1'b0 || instr_count !== '0)
      $display("FAIL trap_reset got=%b ill=%b cnt=%0d exp=0 ill=0 cnt=0",
               got_ctl, illegal, instr_count);
    else n_pass++;
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = '0;
    run_instr(OP_R, 0, 0, -1);
`else
    run_instr(6'b111111, 0, 0, -1);
    run_instr(6'b111111, 2, 0, -1);
    run_instr(OP_J, 0, 0, -1);
`endif
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    logic [5:0] op;
    int         r;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    for (int i = 0; i < 80; i++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      r = int'($urandom_range(0, 5));
`else
      r = int'($urandom_range(0, 6));
`endif
      if (r < 6) op = ops[r];
      else begin
        op = 6'($urandom);
        while (is_sup(op)) op = 6'($urandom);
      end
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    imem_ready = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 15; i++) run_instr(OP_J, 0, 0, -1);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    n_checks++;
    if (instr_count !== 4'd15) $display("FAIL wrap_pre got=%0d exp=15", instr_count);
    else n_pass++;
    run_instr(OP_J, 0, 0, -1);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    n_checks++;
    if (instr_count !== 4'd0 || state !== 3'd0)
      $display("FAIL wrap_post cnt=%0d state=%0d exp cnt=0 state=0", instr_count, state);
    else n_pass++;
  endtask

  initial begin
    exp_cnt = '0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_fetch_wait();
    test_reset_mid_mem();
    test_rtype();
    test_illegal();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multi-cycle sequencer for the single-issue MIPS datapath. It replaces single-cycle control with a FETCH/DECODE/EXEC/MEM/WB state machine. It waits on instruction-memory and data-memory ready handshakes, latches the opcode, and drives the existing datapath mux/enable controls. It pulses the PC enable exactly once per retired instruction and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps)
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load-word opcode
OP_SW, 6'b101011, store-word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_J, 6'b000010, jump opcode
OP_ADDI, 6'b001000, add-immediate opcode

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; one clock, async active-high reset (fixed)
opcode  in  6  instruction bits [31:26]; sampled in DECODE only
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data memory access completes this cycle
ir_load  out  1  capture instruction word
reg_dst  out  1  write-address select (1 = rd)
jump  out  1  jump mux select
branch  out  1  branch enable (ANDed with ALU zero externally)
mem_read  out  1  data memory read enable
mem_write  out  1  data memory write enable
mem_to_reg  out  1  writeback source (1 = memory)
alu_src  out  1  ALU B select (1 = sign-extended immediate)
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
reg_write  out  1  register file write enable
pc_en  out  1  PC update strobe, one cycle per instruction
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (async, any time, including mid-MEM): state=FETCH, op_q=0, instr_count=0. All control outputs 0 while reset is high and in the first FETCH cycle.
- Outputs are Moore-decoded from state and latched op_q. They are 0 in FETCH and DECODE, except ir_load and the skip pc_en described below.
- FETCH: ir_load=imem_ready. Stay in FETCH while imem_ready=0; go to DECODE when imem_ready=1.
- DECODE: op_q<=opcode. Supported opcodes go to EXEC.
  - Unsupported opcode, macro off: pc_en=1 in DECODE, then go to FETCH (treated as a NOP).
- EXEC:
  - R-type: alu_src=0, alu_op=10; go to WB.
  - ADDI: alu_src=1, alu_op=00; go to WB.
  - LW/SW: alu_src=1, alu_op=00; go to MEM.
  - BEQ: alu_src=0, alu_op=01, branch=1, pc_en=1; go to FETCH.
  - J: jump=1, pc_en=1; go to FETCH.
- MEM: alu_src/alu_op held at their EXEC values.
  - LW: mem_read=1 until dmem_ready, then go to WB.
  - SW: mem_write=1; stay while dmem_ready=0. In the dmem_ready cycle pc_en=1, then go to FETCH.
  - No timeout: waits indefinitely.
- WB: reg_write=1, pc_en=1; go to FETCH.
  - reg_dst=1 for R-type only.
  - mem_to_reg=1 for LW only.
  - alu_src/alu_op held at their EXEC values.
- Latency with zero-wait memories: R/ADDI 4 cycles, LW 5, SW 4, BEQ 3, J 3.
- Each wait cycle adds 1 cycle.
- instr_count increments by 1 on every clock edge where pc_en=1; wraps at 2^CNT_W-1 → 0.
- mem_read and mem_write are never high together.
- pc_en is never high in two consecutive cycles.
- reg_write is high only in WB.
- imem_ready and dmem_ready are ignored outside FETCH and MEM respectively.

Optional Feature:
MC_ILLEGAL_TRAP_EN.
- Defined: adds output illegal (1 bit). An unsupported opcode in DECODE goes to TRAP.
  - In TRAP: illegal=1, all other controls 0, pc_en never asserts, instr_count frozen.
  - TRAP is left only by reset.
- Undefined: no illegal port and no TRAP state; unsupported opcodes follow the NOP-skip path.

Test Plan:
- Reset high mid-MEM of an LW with dmem_ready=0 → next sample: state=0, all controls 0, instr_count=0.
- R-type (opcode 000000), imem_ready=dmem_ready=1 → states 0,1,2,4,0; pc_en and reg_write high only in WB with reg_dst=1; instr_count=1.
- LW with dmem_ready low for 3 MEM cycles → mem_read high 4 cycles, then WB with mem_to_reg=1, alu_src=1; total 8 cycles; one pc_en.
- SW then BEQ back-to-back → SW: mem_write 1 cycle, pc_en on MEM exit, reg_write never set. BEQ: branch=1, alu_op=01, pc_en in EXEC. instr_count=2 after 7 cycles.
- imem_ready held 0 for 5 cycles → stays FETCH, ir_load=0, no pc_en. On the ready cycle ir_load=1.
- Opcode 111111 → macro off: pc_en in DECODE, instr_count+1. Macro on: state=5, illegal=1, no pc_en for 20 cycles; reset recovers.
- Run 2^CNT_W J instructions with CNT_W=4 → instr_count wraps 15→0.
